// File: rtl/axi_bank_delay.sv
// axi_bank_delay: DRAM bank/page latency emulator for one AXI valid/ready pair.
// A request seen in IDLE is classified against a per-bank open-page table
// (hit / empty / conflict). The channel is then held closed for the delay of
// that class before being passed through until one handshake completes.
module axi_bank_delay #(
  parameter int ADDR_WIDTH        = 16,
  parameter int PAGE_OFFSET_WIDTH = 6,
  parameter int BANK_BITS         = 2,
  parameter int HIT_DELAY         = 2,
  parameter int EMPTY_DELAY       = 4,
  parameter int CONFLICT_DELAY    = 8,
  parameter int REFRESH_PERIOD    = 64,
  parameter int STAT_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic                  out_ready,
  output logic [1:0]            out_class,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - PAGE_OFFSET_WIDTH - BANK_BITS;
  localparam int MAX_HE    = (HIT_DELAY > EMPTY_DELAY) ? HIT_DELAY : EMPTY_DELAY;
  localparam int MAX_DELAY = (MAX_HE > CONFLICT_DELAY) ? MAX_HE : CONFLICT_DELAY;
  localparam int CNT_WIDTH = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int REF_WIDTH = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  // Countdown load values are delay-1 so that exactly D cycles are spent counting.
  localparam logic [CNT_WIDTH-1:0] HIT_LOAD      = CNT_WIDTH'(HIT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] EMPTY_LOAD    = CNT_WIDTH'(EMPTY_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] CONFLICT_LOAD = CNT_WIDTH'(CONFLICT_DELAY - 1);
  localparam logic [REF_WIDTH-1:0] REF_LAST      =
      (REFRESH_PERIOD > 0) ? REF_WIDTH'(REFRESH_PERIOD - 1) : '0;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_COUNTDOWN = 2'd1;
  localparam logic [1:0] S_ACTIVE    = 2'd2;

  localparam logic [1:0] C_HIT      = 2'd0;
  localparam logic [1:0] C_EMPTY    = 2'd1;
  localparam logic [1:0] C_CONFLICT = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [1:0]            r_class;
  logic [NUM_BANKS-1:0]  r_open;
  logic [TAG_WIDTH-1:0]  r_tag [NUM_BANKS];
  logic [REF_WIDTH-1:0]  r_ref_cnt;
  logic [STAT_WIDTH-1:0] r_hit_cnt;
  logic [STAT_WIDTH-1:0] r_miss_cnt;

  logic [BANK_BITS-1:0]  w_bank;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic                  w_bank_open;
  logic                  w_tag_match;
  logic                  w_is_hit;
  logic                  w_start;
  logic                  w_refresh;
  logic [1:0]            w_class;
  logic [CNT_WIDTH-1:0]  w_load;
  logic                  w_unused_offset;

  assign w_bank      = in_addr[PAGE_OFFSET_WIDTH +: BANK_BITS];
  assign w_tag       = in_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_bank_open = r_open[w_bank];
  assign w_tag_match = (r_tag[w_bank] == w_tag);
  assign w_is_hit    = w_bank_open && w_tag_match;
  assign w_start     = (r_state == S_IDLE) && in_valid;
  assign w_refresh   = (REFRESH_PERIOD != 0) && (r_ref_cnt == REF_LAST);

  // Byte offset within a page has no effect on latency.
  assign w_unused_offset = ^in_addr[PAGE_OFFSET_WIDTH-1:0];

  // Gating is combinational on the state register so reset closes the channel at once.
  assign out_valid  = (r_state == S_ACTIVE) && in_valid;
  assign out_ready  = (r_state == S_ACTIVE) && in_ready;
  assign busy       = (r_state != S_IDLE);
  assign out_class  = r_class;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  // Classify the presented request against the open-page table.
  always_comb begin
    w_class = C_EMPTY;
    w_load  = EMPTY_LOAD;
    if (w_bank_open) begin
      if (w_tag_match) begin
        w_class = C_HIT;
        w_load  = HIT_LOAD;
      end else begin
        w_class = C_CONFLICT;
        w_load  = CONFLICT_LOAD;
      end
    end
  end

  // Main sequencer: IDLE -> COUNTDOWN (D cycles) -> ACTIVE (until one handshake).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_class <= C_HIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_COUNTDOWN;
            r_count <= w_load;
            r_class <= w_class;
          end
        end
        S_COUNTDOWN: begin
          if (r_count == '0) begin
            r_state <= S_ACTIVE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (in_valid && in_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Open-page table: a new open on the refresh edge survives, every other bank closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_open <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (w_start && (w_bank == BANK_BITS'(i))) begin
          r_open[i] <= 1'b1;
          r_tag[i]  <= w_tag;
        end else if (w_refresh) begin
          r_open[i] <= 1'b0;
        end
      end
    end
  end

  // Free-running refresh interval counter, independent of the sequencer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt <= '0;
    end else if (REFRESH_PERIOD == 0 || w_refresh) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  // Saturating hit / miss statistics, updated once per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_start) begin
      if (w_is_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

endmodule
